pe_dbuf_mac: RTL
================

Name: pe_dbuf_mac

Overview:
Second-generation systolic processing element for the Lego SA array. It adds three things:
- a double-buffered (shadow/active) weight register, so weights shift in while MACs continue;
- a signed/unsigned multiply mode;
- a selectable output-stationary accumulate mode alongside the existing weight-stationary psum flow.

Weights chain vertically (normal) or horizontally (transpose). Activations flow right and partial sums flow down, both qualified by valid bits.

Parameters:
- DATA_W, 8: activation and weight width.
- DATA_W_OUT, 32: partial sum and accumulator width. Must be ≥ 2*DATA_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_act  in  DATA_W  activation from left
- in_valid  in  1  in_act valid
- in_psum  in  DATA_W_OUT  partial sum from top
- in_psum_valid  in  1  in_psum valid (OS drain chain)
- w_in_down  in  DATA_W  weight from PE below (normal load)
- w_in_left  in  DATA_W  weight from PE at left (transpose load)
- load_w  in  1  capture weight into shadow
- transpose_en  in  1  select left source / right output
- w_swap  in  1  promote shadow to active
- signed_en  in  1  1 = two's-complement multiply
- os_mode  in  1  0 = weight-stationary, 1 = output-stationary
- acc_clr  in  1  OS: restart accumulation
- drain  in  1  OS: emit accumulator on out_psum
- out_act  out  DATA_W  registered activation to right
- out_valid  out  1  registered in_valid
- out_psum  out  DATA_W_OUT  registered partial sum down
- out_psum_valid  out  1  out_psum valid
- w_out_up  out  DATA_W  shadow weight up; 0 when transpose_en=1
- w_out_right  out  DATA_W  shadow weight right; 0 when transpose_en=0
- w_ready  out  1  shadow holds an unswapped weight
- swap_err  out  1  sticky: swap issued with empty shadow
- sat_flag  out  1  sticky saturation flag (see optional feature)

Behaviour:
- Reset (rst_n=0 at clk edge): all registers cleared, so every output is 0. Synchronous reset mid-operation aborts everything; no partial state survives.
- Weight shadow:
  - load_w=1 → shadow <= transpose_en ? w_in_left : w_in_down; shadow_full <= 1.
  - w_out_up and w_out_right are driven combinationally from the registered shadow, gated by transpose_en.
- Weight swap:
  - w_swap=1 with shadow_full=1 → active <= shadow; shadow_full <= 0.
  - load_w and w_swap in the same cycle: active takes the OLD shadow; the shadow takes the new weight; shadow_full stays 1.
  - w_swap with shadow_full=0 → active unchanged; swap_err <= 1 (sticky until reset).
- w_ready = shadow_full.
- Loading never stalls compute.
- A MAC in the same cycle as a swap uses the pre-swap active weight; the new weight applies from the next cycle.
- Product:
  - signed_en=1: signed(in_act) × signed(active), sign-extended to DATA_W_OUT.
  - signed_en=0: unsigned product, zero-extended.
- Activation path (both modes): out_act <= in_act and out_valid <= 1 when in_valid=1. Otherwise out_valid <= 0 and out_act holds.
- WS mode (os_mode=0):
  - in_valid=1 → out_psum <= in_psum + product; out_psum_valid <= 1.
  - in_valid=0 → out_psum holds; out_psum_valid <= 0.
  - acc_clr, drain and in_psum_valid are ignored.
- OS mode (os_mode=1):
  - Accumulator acc: in_valid=1 → acc <= (acc_clr ? 0 : acc) + product. acc_clr=1 with in_valid=0 → acc <= 0.
  - Psum chain: drain=1 → out_psum <= acc (value before this cycle's update), out_psum_valid <= 1. drain=0 → out_psum <= in_psum, out_psum_valid <= in_psum_valid.
- Arithmetic wraps modulo 2^DATA_W_OUT unless PE_SAT_EN is defined.
- Latency is 1 cycle on every path.
- os_mode changes are legal any cycle; acc is retained across a mode change.

Optional Feature:
PE_SAT_EN
- Defined: the WS adder and OS accumulator saturate.
  - signed_en=1: clamp to [−2^(DATA_W_OUT−1), 2^(DATA_W_OUT−1)−1].
  - signed_en=0: clamp to [0, 2^DATA_W_OUT−1].
  - sat_flag <= 1 on any clamp; it is sticky until reset.
- Undefined: arithmetic wraps; sat_flag is tied 0.

Test Plan:
1. Normal load and MAC: load_w=1, w_in_down=0x03; next cycle w_swap; then in_act=5, in_psum=100, in_valid=1 → next cycle out_psum=115, out_valid=1, out_psum_valid=1. w_out_up=0x03 and w_ready=1 from the cycle after load until the swap.
2. Signed vs unsigned: active=0xFE, in_act=0x05, in_psum=0. signed_en=1 → out_psum=0xFFFFFFF6. signed_en=0 → out_psum=0x000004F6.
3. Double buffer: active=3, stream in_act=2, in_psum=0 every cycle; load 7 mid-stream; swap at cycle k → outputs 6 through cycle k, 14 from cycle k+1. A second w_swap with no load → swap_err=1 and outputs stay 14.
4. Output-stationary: os_mode=1, active=3. Sequence:
   - in_act=4 with acc_clr=1,
   - then in_act=2 twice,
   - then drain=1 → out_psum=24, out_psum_valid=1.
   A drain=0 cycle with in_psum_valid=1, in_psum=0x55 → out_psum=0x55.
5. Transpose and reset: transpose_en=1, load_w, w_in_left=0x09 → w_out_right=0x09, w_out_up=0. Assert rst_n=0 for one edge mid-stream → all outputs 0 the next cycle.
6. Overflow: signed_en=1, WS, in_psum=0x7FFFFFF0, act=5, w=4.
   - With PE_SAT_EN: out_psum=0x7FFFFFFF, sat_flag=1.
   - Without: out_psum=0x80000004, sat_flag=0.

Source files
------------

// File: rtl/pe_dbuf_mac.sv
// Systolic PE with a double-buffered weight, a signed/unsigned multiply and a WS/OS accumulate mode.
// Optional build macro PE_SAT_EN: saturating WS adder and OS accumulator, with a sticky sat_flag.
module pe_dbuf_mac #(
    parameter int DATA_W     = 8,
    parameter int DATA_W_OUT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     in_act,
    input  logic                  in_valid,
    input  logic [DATA_W_OUT-1:0] in_psum,
    input  logic                  in_psum_valid,
    input  logic [DATA_W-1:0]     w_in_down,
    input  logic [DATA_W-1:0]     w_in_left,
    input  logic                  load_w,
    input  logic                  transpose_en,
    input  logic                  w_swap,
    input  logic                  signed_en,
    input  logic                  os_mode,
    input  logic                  acc_clr,
    input  logic                  drain,
    output logic [DATA_W-1:0]     out_act,
    output logic                  out_valid,
    output logic [DATA_W_OUT-1:0] out_psum,
    output logic                  out_psum_valid,
    output logic [DATA_W-1:0]     w_out_up,
    output logic [DATA_W-1:0]     w_out_right,
    output logic                  w_ready,
    output logic                  swap_err,
    output logic                  sat_flag
);

    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0]     shadow_r;
    logic [DATA_W-1:0]     active_r;
    logic                  shadow_full_r;
    logic                  swap_err_r;
    logic [DATA_W-1:0]     out_act_r;
    logic                  out_valid_r;
    logic [DATA_W_OUT-1:0] out_psum_r;
    logic                  out_psum_valid_r;
    logic [DATA_W_OUT-1:0] acc_r;
    logic                  sat_r;

    logic signed [PW-1:0]  prod_sgn_s;
    logic [PW-1:0]         prod_uns_s;
    logic [DATA_W_OUT-1:0] prod_ext_s;
    logic [DATA_W_OUT-1:0] acc_base_s;
    logic [DATA_W_OUT:0]   ws_sum_s;
    logic [DATA_W_OUT:0]   acc_sum_s;
    logic                  swap_ok_s;

    // Returns {clamped, result}; the signedness of the clamp follows signed_en.
    function automatic logic [DATA_W_OUT:0] add_wrap_sat(
        input logic [DATA_W_OUT-1:0] a,
        input logic [DATA_W_OUT-1:0] b
    );
        logic [DATA_W_OUT:0] s;
        logic [DATA_W_OUT:0] r;
`ifdef PE_SAT_EN
        s = {signed_en & a[DATA_W_OUT-1], a} + {signed_en & b[DATA_W_OUT-1], b};
        if (signed_en && (s[DATA_W_OUT] != s[DATA_W_OUT-1])) begin
            r = {1'b1, s[DATA_W_OUT], {(DATA_W_OUT-1){~s[DATA_W_OUT]}}};
        end else if (!signed_en && s[DATA_W_OUT]) begin
            r = {1'b1, {DATA_W_OUT{1'b1}}};
        end else begin
            r = {1'b0, s[DATA_W_OUT-1:0]};
        end
`else
        s = {1'b0, a + b};
        r = s;
`endif
        return r;
    endfunction

    // Product, adder results and swap qualification
    always_comb begin
        prod_sgn_s = $signed({{DATA_W{in_act[DATA_W-1]}}, in_act})
                   * $signed({{DATA_W{active_r[DATA_W-1]}}, active_r});
        prod_uns_s = {{DATA_W{1'b0}}, in_act} * {{DATA_W{1'b0}}, active_r};
        if (signed_en) begin
            prod_ext_s = DATA_W_OUT'(prod_sgn_s);
        end else begin
            prod_ext_s = DATA_W_OUT'(prod_uns_s);
        end
        if (acc_clr) begin
            acc_base_s = {DATA_W_OUT{1'b0}};
        end else begin
            acc_base_s = acc_r;
        end
        ws_sum_s  = add_wrap_sat(in_psum, prod_ext_s);
        acc_sum_s = add_wrap_sat(acc_base_s, prod_ext_s);
        swap_ok_s = w_swap & shadow_full_r;
    end

    // Shadow/active weight double buffer; a swap reads the shadow before any same-cycle load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_r      <= {DATA_W{1'b0}};
            active_r      <= {DATA_W{1'b0}};
            shadow_full_r <= 1'b0;
            swap_err_r    <= 1'b0;
        end else begin
            if (load_w) begin
                shadow_r <= transpose_en ? w_in_left : w_in_down;
            end
            if (swap_ok_s) begin
                active_r <= shadow_r;
            end
            if (load_w) begin
                shadow_full_r <= 1'b1;
            end else if (swap_ok_s) begin
                shadow_full_r <= 1'b0;
            end
            if (w_swap && !shadow_full_r) begin
                swap_err_r <= 1'b1;
            end
        end
    end

    // Activation forwarding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_act_r   <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                out_act_r <= in_act;
            end
        end
    end

    // Psum chain and OS accumulator; drain emits the accumulator value from before this cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_psum_r       <= {DATA_W_OUT{1'b0}};
            out_psum_valid_r <= 1'b0;
            acc_r            <= {DATA_W_OUT{1'b0}};
            sat_r            <= 1'b0;
        end else if (!os_mode) begin
            out_psum_valid_r <= in_valid;
            if (in_valid) begin
                out_psum_r <= ws_sum_s[DATA_W_OUT-1:0];
                if (ws_sum_s[DATA_W_OUT]) begin
                    sat_r <= 1'b1;
                end
            end
        end else begin
            if (in_valid) begin
                acc_r <= acc_sum_s[DATA_W_OUT-1:0];
                if (acc_sum_s[DATA_W_OUT]) begin
                    sat_r <= 1'b1;
                end
            end else if (acc_clr) begin
                acc_r <= {DATA_W_OUT{1'b0}};
            end
            if (drain) begin
                out_psum_r       <= acc_r;
                out_psum_valid_r <= 1'b1;
            end else begin
                out_psum_r       <= in_psum;
                out_psum_valid_r <= in_psum_valid;
            end
        end
    end

    assign out_act        = out_act_r;
    assign out_valid      = out_valid_r;
    assign out_psum       = out_psum_r;
    assign out_psum_valid = out_psum_valid_r;
    assign w_out_up       = transpose_en ? {DATA_W{1'b0}} : shadow_r;
    assign w_out_right    = transpose_en ? shadow_r : {DATA_W{1'b0}};
    assign w_ready        = shadow_full_r;
    assign swap_err       = swap_err_r;
    assign sat_flag       = sat_r;

endmodule
